fusion_seq_ctrl: RTL and testbench

- Sequences one fusion_unit through a dot-product job.
- Accepts a job configuration: operand widths, signedness and vector length.
- Streams 4-bit input/weight pairs into the unit, tracks its one-cycle registered psum latency, and accumulates the psums into wide accumulators.
- Returns the result over a valid/ready handshake. Sits between the operand buffers and one fusion unit in each PE.

---
 rtl/fusion_pkg.sv | 20 ++
 rtl/fusion_seq_ctrl_if.sv | 59 +++++
 rtl/fusion_acc_lane.sv | 37 +++
 rtl/fusion_seq_ctrl.sv | 119 +++++++++++
 tb/tb_fusion_seq_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/fusion_pkg.sv
// Shared definitions for the fusion sequencer: width codes, psum geometry, FSM states.
// No logic; imported by the interface, the top and the accumulator lane.
// Width codes are one-hot: bit 2 = 4-bit, bit 1 = 2-bit, bit 0 = 1-bit operands.
package fusion_pkg;

  localparam logic [2:0] W4 = 3'b100;
  localparam logic [2:0] W2 = 3'b010;
  localparam logic [2:0] W1 = 3'b001;

  localparam int PSUM_W = 18;
  localparam int LANE_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fusion_seq_ctrl_if.sv
// Bus bundle between operand buffers, one fusion unit and the sequencer.
// Groups the config, operand, fusion-unit and result channels.
// slave = sequencer view; master = surrounding PE / environment view.
interface fusion_seq_ctrl_if #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
);
  import fusion_pkg::*;

  // job configuration (valid/ready)
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_in_width;
  logic [2:0]        cfg_weight_width;
  logic              cfg_s_in;
  logic              cfg_s_weight;
  logic [LEN_W-1:0]  cfg_len;
  // operand pair stream (valid/ready)
  logic              op_valid;
  logic              op_ready;
  logic [3:0]        op_in;
  logic [3:0]        op_weight;
  // fusion unit side
  logic [3:0]        fu_in;
  logic [3:0]        fu_weight;
  logic [2:0]        fu_in_width;
  logic [2:0]        fu_weight_width;
  logic              fu_s_in;
  logic              fu_s_weight;
  logic [PSUM_W-1:0] fu_psum;
  // result (valid/ready)
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_acc0;
  logic [ACC_W-1:0]  res_acc1;

  modport slave (
    input  cfg_valid, cfg_in_width, cfg_weight_width, cfg_s_in, cfg_s_weight, cfg_len,
    output cfg_ready,
    input  op_valid, op_in, op_weight,
    output op_ready,
    output fu_in, fu_weight, fu_in_width, fu_weight_width, fu_s_in, fu_s_weight,
    input  fu_psum,
    output res_valid, res_acc0, res_acc1,
    input  res_ready
  );

  modport master (
    output cfg_valid, cfg_in_width, cfg_weight_width, cfg_s_in, cfg_s_weight, cfg_len,
    input  cfg_ready,
    output op_valid, op_in, op_weight,
    input  op_ready,
    input  fu_in, fu_weight, fu_in_width, fu_weight_width, fu_s_in, fu_s_weight,
    output fu_psum,
    input  res_valid, res_acc0, res_acc1,
    output res_ready
  );

endinterface

// File: rtl/fusion_acc_lane.sv
// One accumulator lane: extends an ADD_W addend (sign or zero) and adds it into ACC_W.
// Latency: sum visible the cycle after i_en; wraps modulo 2^ACC_W, no saturation.
// No backpressure. Ports: clk, rst, i_clr (sync clear), i_en, i_signed, i_addend, o_acc.
module fusion_acc_lane #(
  parameter int ADD_W = 9,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_signed,
  input  logic [ADD_W-1:0] i_addend,
  output logic [ACC_W-1:0] o_acc
);

  logic signed [ADD_W-1:0] w_add_s;
  logic        [ACC_W-1:0] w_ext;
  logic        [ACC_W-1:0] r_acc;

  assign w_add_s = i_addend;
  // a size cast of a signed operand sign-extends; of an unsigned one, zero-extends
  assign w_ext   = i_signed ? ACC_W'(w_add_s) : ACC_W'(i_addend);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/fusion_seq_ctrl.sv
// Sequences one fusion unit through a dot-product job and accumulates its psums.
// Latency: last operand accept to res_valid is 3 cycles; one pair per cycle in RUN.
// Backpressure: cfg_ready only in IDLE, op_ready only in RUN, result held until res_ready.
// Ports: clk, rst (sync, active-high), bus (fusion_seq_ctrl_if.slave).
module fusion_seq_ctrl #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  fusion_seq_ctrl_if.slave   bus
);
  import fusion_pkg::*;

  state_t            r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len, r_count;
  logic              r_split, r_signed;
  logic              r_v1, r_v2;          // v1: fu_in/fu_weight valid, v2: fu_psum valid
  logic [3:0]        r_fu_in, r_fu_weight;
  logic [2:0]        r_in_w, r_wt_w;
  logic              r_s_in, r_s_wt;
  logic              w_cfg_fire, w_op_rdy, w_op_fire, w_last;
  logic              w_res_valid;
  logic [PSUM_W-1:0] w_lane0_add;

  assign bus.cfg_ready = (r_state == IDLE);
  assign w_op_rdy      = (r_state == RUN) && (r_count < r_len);
  assign bus.op_ready  = w_op_rdy;
  assign w_cfg_fire    = bus.cfg_valid & (r_state == IDLE);
  assign w_op_fire     = bus.op_valid & w_op_rdy;
  assign w_last        = w_op_fire && ((r_count + 1'b1) == r_len);

  always_comb begin
    w_state_nxt = r_state;
    w_res_valid = 1'b0;
    case (r_state)
      IDLE:    if (bus.cfg_valid) w_state_nxt = (bus.cfg_len == '0) ? DONE : RUN;
      RUN:     if (w_last) w_state_nxt = DRAIN;
      DRAIN:   if (!r_v1 && !r_v2) w_state_nxt = DONE;
      DONE: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_split     <= 1'b0;
      r_signed    <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_fu_in     <= '0;
      r_fu_weight <= '0;
      r_in_w      <= W4;
      r_wt_w      <= W4;
      r_s_in      <= 1'b0;
      r_s_wt      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // bubbles present zero operands so the unit never sees stale data
      r_v1        <= w_op_fire;
      r_v2        <= r_v1;
      r_fu_in     <= w_op_fire ? bus.op_in     : 4'd0;
      r_fu_weight <= w_op_fire ? bus.op_weight : 4'd0;
      if (w_cfg_fire) begin
        r_len    <= bus.cfg_len;
        r_count  <= '0;
        r_split  <= (bus.cfg_weight_width != W4);
        r_signed <= bus.cfg_s_in | bus.cfg_s_weight;
        r_in_w   <= bus.cfg_in_width;
        r_wt_w   <= bus.cfg_weight_width;
        r_s_in   <= bus.cfg_s_in;
        r_s_wt   <= bus.cfg_s_weight;
      end else if (w_op_fire) begin
        r_count  <= r_count + 1'b1;
      end
    end
  end

  assign bus.fu_in           = r_fu_in;
  assign bus.fu_weight       = r_fu_weight;
  assign bus.fu_in_width     = r_in_w;
  assign bus.fu_weight_width = r_wt_w;
  assign bus.fu_s_in         = r_s_in;
  assign bus.fu_s_weight     = r_s_wt;
  assign bus.res_valid       = w_res_valid;

  // split mode: lane0 is the low 9-bit lane, pre-extended to 18 so one lane
  // instance serves both modes; full mode passes the 18-bit total straight in
  assign w_lane0_add = r_split
    ? {{(PSUM_W-LANE_W){r_signed & bus.fu_psum[LANE_W-1]}}, bus.fu_psum[LANE_W-1:0]}
    : bus.fu_psum;

  fusion_acc_lane #(.ADD_W(PSUM_W), .ACC_W(ACC_W)) u_lane0 (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cfg_fire),
    .i_en     (r_v2),
    .i_signed (r_signed),
    .i_addend (w_lane0_add),
    .o_acc    (bus.res_acc0)
  );

  fusion_acc_lane #(.ADD_W(LANE_W), .ACC_W(ACC_W)) u_lane1 (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_cfg_fire),
    .i_en     (r_v2 & r_split),
    .i_signed (r_signed),
    .i_addend (bus.fu_psum[PSUM_W-1:LANE_W]),
    .o_acc    (bus.res_acc1)
  );

endmodule

// File: tb/tb_fusion_seq_ctrl.sv
// Directed bench for fusion_seq_ctrl: behavioural fusion unit (or a constant psum stub),
// hand-computed expected sums, handshake latency and reset-abort checks.
// Second instance with ACC_W=18 exercises accumulator wrap.
module tb_fusion_seq_ctrl;
  import fusion_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  fusion_seq_ctrl_if #(.LEN_W(8), .ACC_W(32)) a_if ();
  fusion_seq_ctrl_if #(.LEN_W(8), .ACC_W(18)) b_if ();

  fusion_seq_ctrl #(.LEN_W(8), .ACC_W(32)) u_dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  fusion_seq_ctrl #(.LEN_W(8), .ACC_W(18)) u_dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  // behavioural fusion unit: registered 4b x 4b product, or a constant stub psum
  logic        a_stub_en;
  logic [17:0] a_stub;

  function automatic logic [17:0] fu_model(logic [3:0] a, logic [3:0] b, logic sa, logic sb);
    int x, y;
    x = sa ? int'($signed(a)) : int'(a);
    y = sb ? int'($signed(b)) : int'(b);
    return 18'(x * y);
  endfunction

  always_ff @(posedge clk) begin
    a_if.fu_psum <= a_stub_en ? a_stub
                  : fu_model(a_if.fu_in, a_if.fu_weight, a_if.fu_s_in, a_if.fu_s_weight);
    b_if.fu_psum <= 18'h3FFFF;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_a(input logic [2:0] iw, input logic [2:0] ww, input logic si,
                       input logic sw, input logic [7:0] len);
    logic ok;
    ok = 1'b0;
    a_if.cfg_in_width     = iw;
    a_if.cfg_weight_width = ww;
    a_if.cfg_s_in         = si;
    a_if.cfg_s_weight     = sw;
    a_if.cfg_len          = len;
    a_if.cfg_valid        = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok = a_if.cfg_ready;
      tick();
      if (ok) break;
    end
    if (!ok) check("cfg_timeout", 64'd0, 64'd1);
    a_if.cfg_valid = 1'b0;
  endtask

  // leaves op_valid high so back-to-back calls stream without bubbles
  task automatic op_a(input logic [3:0] in, input logic [3:0] w);
    logic ok;
    ok = 1'b0;
    a_if.op_in     = in;
    a_if.op_weight = w;
    a_if.op_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok = a_if.op_ready;
      tick();
      if (ok) break;
    end
    if (!ok) check("op_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_res_a(output int lat);
    lat = 0;
    while (!a_if.res_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!a_if.res_valid) check("res_timeout", 64'd0, 64'd1);
  endtask

  task automatic take_res_a();
    a_if.res_ready = 1'b1;
    tick();
    a_if.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    a_stub_en = 1'b0;
    a_stub = '0;
    a_if.cfg_valid = 0; a_if.cfg_in_width = W4; a_if.cfg_weight_width = W4;
    a_if.cfg_s_in = 0; a_if.cfg_s_weight = 0; a_if.cfg_len = '0;
    a_if.op_valid = 0; a_if.op_in = '0; a_if.op_weight = '0; a_if.res_ready = 0;
    b_if.cfg_valid = 0; b_if.cfg_in_width = W4; b_if.cfg_weight_width = W4;
    b_if.cfg_s_in = 0; b_if.cfg_s_weight = 0; b_if.cfg_len = '0;
    b_if.op_valid = 0; b_if.op_in = '0; b_if.op_weight = '0; b_if.res_ready = 0;
    repeat (3) tick();

    // reset state
    check("rst_cfg_ready", a_if.cfg_ready, 1);
    check("rst_op_ready", a_if.op_ready, 0);
    check("rst_res_valid", a_if.res_valid, 0);
    check("rst_fu_in", a_if.fu_in, 0);
    check("rst_fu_weight", a_if.fu_weight, 0);
    check("rst_fu_in_width", a_if.fu_in_width, W4);
    check("rst_fu_wt_width", a_if.fu_weight_width, W4);
    check("rst_fu_s", {a_if.fu_s_in, a_if.fu_s_weight}, 0);
    check("rst_acc0", a_if.res_acc0, 0);
    check("rst_acc1", a_if.res_acc1, 0);
    rst = 1'b0;
    tick();

    // unsigned 4b x 4b back-to-back: 225 + 6 + 0 = 231, result 3 cycles after last accept
    cfg_a(W4, W4, 1'b0, 1'b0, 8'd3);
    op_a(4'd15, 4'd15);
    op_a(4'd3, 4'd2);
    op_a(4'd0, 4'd7);
    a_if.op_valid = 1'b0;
    wait_res_a(lat);
    check("t1_latency", lat, 3);
    check("t1_acc0", a_if.res_acc0, 231);
    check("t1_acc1", a_if.res_acc1, 0);
    take_res_a();
    check("t1_cfg_ready_after", a_if.cfg_ready, 1);

    // signed: -8 * 7 = -56
    cfg_a(W4, W4, 1'b1, 1'b1, 8'd1);
    op_a(4'b1000, 4'b0111);
    a_if.op_valid = 1'b0;
    wait_res_a(lat);
    check("t2_acc0", a_if.res_acc0, 64'hFFFFFFC8);
    check("t2_acc1", a_if.res_acc1, 0);
    take_res_a();

    // split mode stub {-1, 3} per op with 2-cycle gaps; bubbles must not add
    a_stub_en = 1'b1;
    a_stub = {9'h1FF, 9'h003};
    cfg_a(W4, W2, 1'b1, 1'b1, 8'd4);
    check("t3_fu_wt_width", a_if.fu_weight_width, W2);
    check("t3_fu_s", {a_if.fu_s_in, a_if.fu_s_weight}, 2'b11);
    for (int i = 0; i < 4; i++) begin
      op_a(4'(i), 4'(i + 1));
      a_if.op_valid = 1'b0;
      tick();
      tick();
    end
    wait_res_a(lat);
    check("t3_acc1", a_if.res_acc1, 64'hFFFFFFFC);
    check("t3_acc0", a_if.res_acc0, 12);
    take_res_a();
    a_stub_en = 1'b0;

    // zero-length job: DONE right after config, result held while res_ready low
    cfg_a(W4, W4, 1'b0, 1'b0, 8'd0);
    check("t4_res_valid", a_if.res_valid, 1);
    check("t4_acc0", a_if.res_acc0, 0);
    check("t4_acc1", a_if.res_acc1, 0);
    check("t4_fu_wt_width", a_if.fu_weight_width, W4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", a_if.res_valid, 1);
      check("t4_hold_cfg_ready", a_if.cfg_ready, 0);
    end
    check("t4_hold_acc0", a_if.res_acc0, 0);
    take_res_a();
    check("t4_idle_cfg_ready", a_if.cfg_ready, 1);
    check("t4_idle_res_valid", a_if.res_valid, 0);

    // reset mid-job after 2 of 5 accepts, then a fresh 5x5 job
    cfg_a(W4, W4, 1'b0, 1'b0, 8'd5);
    op_a(4'd1, 4'd1);
    op_a(4'd2, 4'd2);
    a_if.op_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("t5_rst_cfg_ready", a_if.cfg_ready, 1);
    check("t5_rst_res_valid", a_if.res_valid, 0);
    check("t5_rst_op_ready", a_if.op_ready, 0);
    rst = 1'b0;
    cfg_a(W4, W4, 1'b0, 1'b0, 8'd1);
    op_a(4'd5, 4'd5);
    a_if.op_valid = 1'b0;
    wait_res_a(lat);
    check("t5_lat", lat, 3);
    check("t5_acc0", a_if.res_acc0, 25);
    take_res_a();

    // wrap: 2 x 18'h3FFFF into an 18-bit accumulator = 18'h3FFFE
    b_if.cfg_len = 8'd2;
    b_if.cfg_valid = 1'b1;
    tick();
    b_if.cfg_valid = 1'b0;
    b_if.op_valid = 1'b1;
    tick();
    tick();
    b_if.op_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (b_if.res_valid) break;
      tick();
    end
    check("t6_res_valid", b_if.res_valid, 1);
    check("t6_acc0", b_if.res_acc0, 18'h3FFFE);
    check("t6_acc1", b_if.res_acc1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
